stream_mux2to1_arb: RTL and testbench

//  Merges two valid/ready data streams into one output stream: the gathering counterpart of the 1:2 demux.
//  A round-robin arbiter with a burst limit picks the source.
//  One registered output stage gives 1-cycle latency and full throughput.

---
 rtl/stream_mux2to1_arb.sv | 97 +++++++++
 tb/tb_stream_mux2to1_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux2to1_arb.sv
// stream_mux2to1_arb: merges two valid/ready streams through one registered stage, round-robin with burst limit.
// Define MUX_SRC_TAG_EN to register the source index of each word on out_src_o (otherwise tied 0).
module stream_mux2to1_arb #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_data_i,
    input  logic              in0_valid_i,
    output logic              in0_ready_o,
    input  logic [DATA_W-1:0] in1_data_i,
    input  logic              in1_valid_i,
    output logic              in1_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_src_o
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              load_ok, src, own_v, oth_v, xfer;
    state_t            other;

    always_comb begin
        load_ok     = ~valid_q | out_ready_i;
        src         = state_q == GRANT1;
        own_v       = src ? in1_valid_i : in0_valid_i;
        oth_v       = src ? in0_valid_i : in1_valid_i;
        other       = src ? GRANT0 : GRANT1;
        in0_ready_o = ~rst & (state_q == GRANT0) & load_ok;
        in1_ready_o = ~rst & (state_q == GRANT1) & load_ok;
        xfer        = (in0_ready_o & in0_valid_i) | (in1_ready_o & in1_valid_i);
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        if (state_q == IDLE) begin
            if (in0_valid_i | in1_valid_i)
                state_d = (in0_valid_i & (~in1_valid_i | last_q)) ? GRANT0 : GRANT1;
            cnt_d = '0;
        end else if (xfer) begin
            last_d = src;
            // burst limit only bites while the other side waits; otherwise the count saturates
            if (oth_v && cnt_q == CNT_MAX) begin
                state_d = other;
                cnt_d   = '0;
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
            end
        end else if (~own_v) begin
            state_d = oth_v ? other : IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= xfer | (valid_q & ~out_ready_i);
            if (xfer)
                data_q <= src ? in1_data_i : in0_data_i;
        end
    end

`ifdef MUX_SRC_TAG_EN
    logic src_q;

    always_ff @(posedge clk) begin
        if (rst)
            src_q <= 1'b0;
        else if (xfer)
            src_q <= src;
    end

    assign out_src_o = src_q;
`else
    assign out_src_o = 1'b0;
`endif

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
endmodule

// File: tb/tb_stream_mux2to1_arb.sv
// tb_stream_mux2to1_arb: vector table for reset/arbitration steps, scoreboard runs for streaming, stall and reset corners.
module tb_stream_mux2to1_arb;
`ifdef MUX_SRC_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in0_data = '0, in1_data = '0;
    logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b1;
    logic       in0_ready, in1_ready, out_valid, out_src;
    logic [7:0] out_data;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       rst, v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy, r0, r1, ov;
        logic [7:0] od;
        logic       src;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       s;
    } exp_t;

    vec_t       tbl[11];
    exp_t       exp_q[$];
    logic [7:0] q0[$], q1[$];
    int         span;

    always #5 clk = ~clk;

    stream_mux2to1_arb #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .in0_data_i(in0_data), .in0_valid_i(in0_valid), .in0_ready_o(in0_ready),
        .in1_data_i(in1_data), .in1_valid_i(in1_valid), .in1_ready_o(in1_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_src_o(out_src)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        exp_q.push_back('{d, TAG ? s : 1'b0});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
    endtask

    task automatic run(input string nm, input int budget, input int st_lo, input int st_hi,
                       input int st0, input int st1);
        int         cyc = 0;
        int         first = -1;
        int         last = -1;
        logic       stalled = 1'b0;
        logic [7:0] pd = '0;
        exp_t       e;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            out_ready = !(cyc >= st_lo && cyc < st_hi);
            in0_valid = q0.size() > 0 && cyc >= st0;
            in0_data  = q0.size() > 0 ? q0[0] : 8'h00;
            in1_valid = q1.size() > 0 && cyc >= st1;
            in1_data  = q1.size() > 0 ? q1[0] : 8'h00;
            #1;
            if (stalled) begin
                chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
                chk({nm, " hold_data"}, 32'(out_data), 32'(pd));
            end
            if (out_valid && !out_ready)
                chk({nm, " stall_ready"}, {in0_ready, in1_ready}, 32'd0);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chk({nm, " data"}, 32'(out_data), 32'(e.d));
                chk({nm, " src"}, 32'(out_src), 32'(e.s));
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (in0_valid && in0_ready) void'(q0.pop_front());
            if (in1_valid && in1_ready) void'(q1.pop_front());
            stalled = out_valid && !out_ready;
            pd      = out_data;
            cyc++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL %s timeout: %0d words missing", nm, exp_q.size());
        end
        span = last - first;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    initial begin
        // rst, v0, d0, v1, d1, ordy | r0, r1, ov, od, src
        tbl[0]  = '{1, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{0, 1, 8'hA0, 1, 8'hB0, 1, 0, 0, 0, 8'h00, 0};
        tbl[3]  = '{0, 1, 8'hA0, 1, 8'hB0, 1, 1, 0, 0, 8'h00, 0};
        tbl[4]  = '{0, 1, 8'hA1, 1, 8'hB0, 1, 1, 0, 1, 8'hA0, 0};
        tbl[5]  = '{0, 1, 8'hA2, 1, 8'hB0, 0, 0, 0, 1, 8'hA1, 0};
        tbl[6]  = '{0, 1, 8'hA2, 1, 8'hB0, 1, 1, 0, 1, 8'hA1, 0};
        tbl[7]  = '{0, 1, 8'hA3, 1, 8'hB0, 1, 1, 0, 1, 8'hA2, 0};
        tbl[8]  = '{0, 1, 8'hA4, 1, 8'hB0, 1, 0, 1, 1, 8'hA3, 0};
        tbl[9]  = '{0, 0, 8'hA4, 0, 8'hB1, 1, 0, 1, 1, 8'hB0, 1};
        tbl[10] = '{0, 0, 8'hA4, 0, 8'hB1, 1, 0, 0, 0, 8'hB0, 1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst       = tbl[i].rst;
            in0_valid = tbl[i].v0;
            in0_data  = tbl[i].d0;
            in1_valid = tbl[i].v1;
            in1_data  = tbl[i].d1;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d ready", i), {in0_ready, in1_ready}, {tbl[i].r0, tbl[i].r1});
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d data", i), 32'(out_data), 32'(tbl[i].od));
            chk($sformatf("vec%0d src", i), 32'(out_src), 32'(TAG & tbl[i].src));
        end

        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'h10 + 8'(i));
            push(8'h10 + 8'(i), 1'b0);
        end
        run("single", 40, -1, -1, 0, 0);
        chk("single gapless", 32'(span), 32'd7);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'hA0 + 8'(i));
            q1.push_back(8'hB0 + 8'(i));
        end
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i), 1'b1);
        for (int i = 4; i < 8; i++) push(8'hA0 + 8'(i), 1'b0);
        for (int i = 4; i < 8; i++) push(8'hB0 + 8'(i), 1'b1);
        run("burst", 60, -1, -1, 0, 0);
        chk("burst gapless", 32'(span), 32'd15);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'h40 + 8'(i));
            push(8'h40 + 8'(i), 1'b0);
        end
        run("stall", 60, 4, 9, 0, 0);
        chk("stall span", 32'(span), 32'd12);

        do_reset();
        q1.push_back(8'hC0);
        q1.push_back(8'hC1);
        push(8'hC0, 1'b1);
        push(8'hC1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(8'hD0 + 8'(i));
            push(8'hD0 + 8'(i), 1'b0);
        end
        run("handover", 40, -1, -1, 1, 0);
        chk("handover span", 32'(span), 32'd6);

        do_reset();
        @(negedge clk);
        in0_valid = 1'b1;
        in0_data  = 8'h60;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rstmid accept", 32'(in0_ready), 32'd1);
        @(negedge clk);
        in0_data = 8'h61;
        #1;
        chk("rstmid loaded", {out_valid, out_data}, {1'b1, 8'h60});
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid cleared", {out_valid, out_data, out_src}, 32'd0);
        chk("rstmid ready_rst", {in0_ready, in1_ready}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rstmid idle", {in0_ready, in1_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("rstmid regrant", {in0_ready, in1_ready}, 32'b10);
        in0_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
